eight_demux: RTL and testbench

Registered 1-to-8 demultiplexer: the distribution-side counterpart of the 8:1 select multiplexer used in the control path. It takes one valid/ready input stream tagged with a 3-bit destination select and delivers each word into one of eight independent one-entry output buffers. Each buffer has its own valid/ready handshake. Control-unit result fan-out uses it to route one producer to up to eight consumers without combinational paths between consumers.

---
 rtl/eight_demux_if.sv | 33 +++
 rtl/eight_demux.sv | 57 +++++
 tb/tb_eight_demux.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/eight_demux_if.sv
// Handshake bundle for the 1-to-8 registered demultiplexer: one tagged input
// stream and eight independent buffered output streams.
interface eight_demux_if #(
  parameter int unsigned width = 12
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [width-1:0] in_data;
  logic [2:0]       in_select;
  logic [7:0]       out_valid;
  logic [7:0]       out_ready;
  logic [width-1:0] d0;
  logic [width-1:0] d1;
  logic [width-1:0] d2;
  logic [width-1:0] d3;
  logic [width-1:0] d4;
  logic [width-1:0] d5;
  logic [width-1:0] d6;
  logic [width-1:0] d7;

  // Producer/consumer side.
  modport master (
    output flush, in_valid, in_data, in_select, out_ready,
    input  in_ready, out_valid, d0, d1, d2, d3, d4, d5, d6, d7
  );

  // Demultiplexer side.
  modport slave (
    input  flush, in_valid, in_data, in_select, out_ready,
    output in_ready, out_valid, d0, d1, d2, d3, d4, d5, d6, d7
  );
endinterface

// File: rtl/eight_demux.sv
// Registered 1-to-8 demultiplexer: routes a select-tagged input stream into
// eight one-entry output buffers, each with its own valid/ready handshake.
module eight_demux #(
  parameter int unsigned width = 12
) (
  input  logic         clk,
  input  logic         rst,
  eight_demux_if.slave bus
);

  logic [7:0]       v_q, v_d;
  logic [width-1:0] d_q [8];
  logic [width-1:0] d_d [8];
  logic             in_fire;

  // Only the selected channel gates the input; a draining buffer can reload.
  assign bus.in_ready = !bus.flush &&
                        (!v_q[bus.in_select] || bus.out_ready[bus.in_select]);
  assign in_fire      = bus.in_valid && bus.in_ready;

  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (bus.flush) begin
      v_d = 8'h00;
    end else begin
      v_d = v_q & ~bus.out_ready;
      if (in_fire) begin
        v_d[bus.in_select] = 1'b1;
        d_d[bus.in_select] = bus.in_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= 8'h00;
      for (int k = 0; k < 8; k++) begin
        d_q[k] <= '0;
      end
    end else begin
      v_q <= v_d;
      d_q <= d_d;
    end
  end

  assign bus.out_valid = v_q;
  assign bus.d0        = d_q[0];
  assign bus.d1        = d_q[1];
  assign bus.d2        = d_q[2];
  assign bus.d3        = d_q[3];
  assign bus.d4        = d_q[4];
  assign bus.d5        = d_q[5];
  assign bus.d6        = d_q[6];
  assign bus.d7        = d_q[7];

endmodule

// File: tb/tb_eight_demux.sv
// Directed bench for eight_demux: reference model of the buffers plus a queue
// of accepted words that are checked on the DUT outputs after each edge.
module tb_eight_demux;

  localparam int unsigned Width = 12;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [7:0]       v_m;
  logic [Width-1:0] d_m [8];

  typedef struct packed {
    logic [2:0]       sel;
    logic [Width-1:0] data;
  } sb_item_t;
  sb_item_t sb_q [$];

  eight_demux_if #(.width(Width)) bus ();

  eight_demux #(.width(Width)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [Width-1:0] dsel(input int k);
    case (k)
      0:       return bus.d0;
      1:       return bus.d1;
      2:       return bus.d2;
      3:       return bus.d3;
      4:       return bus.d4;
      5:       return bus.d5;
      6:       return bus.d6;
      default: return bus.d7;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at negedge, check in_ready, then outputs after the edge.
  task automatic cycle(input logic valid, input logic [2:0] sel, input logic [Width-1:0] data,
                       input logic [7:0] ordy, input logic fl, input string tag);
    logic     exp_rdy;
    sb_item_t it;
    @(negedge clk);
    bus.in_valid  = valid;
    bus.in_select = sel;
    bus.in_data   = data;
    bus.out_ready = ordy;
    bus.flush     = fl;
    #1;
    exp_rdy = !fl && (!v_m[sel] || ordy[sel]);
    check({tag, " in_ready"}, {31'd0, bus.in_ready}, {31'd0, exp_rdy});
    if (fl) begin
      v_m = 8'h00;
    end else begin
      v_m = v_m & ~ordy;
      if (valid && exp_rdy) begin
        v_m[sel] = 1'b1;
        d_m[sel] = data;
        sb_q.push_back('{sel: sel, data: data});
      end
    end
    @(posedge clk);
    #1;
    check({tag, " out_valid"}, {24'd0, bus.out_valid}, {24'd0, v_m});
    while (sb_q.size() > 0) begin
      it = sb_q.pop_front();
      check({tag, " d_sel"}, {20'd0, dsel(int'(it.sel))}, {20'd0, it.data});
    end
  endtask

  task automatic check_all_d(input string tag);
    for (int k = 0; k < 8; k++) begin
      check(tag, {20'd0, dsel(k)}, {20'd0, d_m[k]});
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_select = 3'd0;
    bus.in_data = '0;
    bus.out_ready = 8'h00;
    v_m = 8'h00;
    for (int k = 0; k < 8; k++) d_m[k] = '0;

    // Reset state.
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset out_valid", {24'd0, bus.out_valid}, 32'h0);
    check("reset in_ready", {31'd0, bus.in_ready}, 32'h1);
    check_all_d("reset d");

    // Fan-out: one word per channel with all consumers stalled.
    for (int k = 0; k < 8; k++) begin
      cycle(1'b1, 3'(k), 12'h100 + 12'(k), 8'h00, 1'b0, "fanout");
    end
    check("fanout full", {24'd0, bus.out_valid}, 32'hFF);
    check("fanout d3", {20'd0, bus.d3}, 32'h103);
    check("fanout d7", {20'd0, bus.d7}, 32'h107);
    check_all_d("fanout d");
    cycle(1'b1, 3'd3, 12'h333, 8'h00, 1'b0, "ninth");
    check("ninth d3 kept", {20'd0, bus.d3}, 32'h103);

    // Back-pressure on channel 5, then release with same-cycle reload.
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 3'd5, 12'hABC, 8'h00, 1'b0, "bp stall");
    end
    check("bp d5 held", {20'd0, bus.d5}, 32'h105);
    cycle(1'b1, 3'd5, 12'hABC, 8'h20, 1'b0, "bp release");
    check("bp v5", {31'd0, bus.out_valid[5]}, 32'h1);
    check("bp d5", {20'd0, bus.d5}, 32'hABC);

    // Asynchronous reset mid-cycle while every buffer is full.
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.out_ready = 8'h00;
    #2;
    rst = 1'b1;
    #1;
    v_m = 8'h00;
    for (int k = 0; k < 8; k++) d_m[k] = '0;
    check("async rst out_valid", {24'd0, bus.out_valid}, 32'h0);
    check_all_d("async rst d");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("post rst in_ready", {31'd0, bus.in_ready}, 32'h1);

    // Streaming to channel 2 with its consumer always ready.
    for (int i = 1; i <= 16; i++) begin
      cycle(1'b1, 3'd2, 12'(i), 8'h04, 1'b0, "stream");
    end
    check("stream last d2", {20'd0, bus.d2}, 32'h010);
    cycle(1'b0, 3'd2, 12'h000, 8'h04, 1'b0, "drain");

    // Flush with four full buffers and a pending input to channel 6.
    for (int k = 0; k < 4; k++) begin
      cycle(1'b1, 3'(k), 12'h200 + 12'(k), 8'h00, 1'b0, "fill");
    end
    check("fill v", {24'd0, bus.out_valid}, 32'h0F);
    cycle(1'b1, 3'd6, 12'h666, 8'h01, 1'b1, "flush");
    check("flush v", {24'd0, bus.out_valid}, 32'h00);
    check("flush d6", {20'd0, bus.d6}, 32'h000);
    check("flush d1", {20'd0, bus.d1}, 32'h201);
    cycle(1'b1, 3'd6, 12'h666, 8'h00, 1'b0, "after flush");
    check("after flush v", {24'd0, bus.out_valid}, 32'h40);
    check("after flush d6", {20'd0, bus.d6}, 32'h666);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
